// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the serial adder controllers.
//  state_t : FSM state encoding (IDLE=0, RUN=1, DONE=2; 3 is unused and recovers to IDLE)
//  clog2   : counter width helper, never smaller than one bit
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to count 0..w-1; a single-bit add still gets a 1-bit counter.
    function automatic int unsigned clog2(input int unsigned w);
        if (w <= 1) begin
            return 1;
        end
        return 32'($clog2(w));
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// Gate-level 1-bit full adder shared by the serial controllers.
//  a, b : operand bits
//  ci   : carry in
//  s    : sum bit     (a ^ b ^ ci)
//  co   : carry out   ((a & b) | (ci & (a ^ b)))
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ab_xor;
    logic ab_and;
    logic ci_and;

    xor g_xor_ab  (ab_xor, a, b);
    xor g_xor_sum (s, ab_xor, ci);
    and g_and_ab  (ab_and, a, b);
    and g_and_ci  (ci_and, ci, ab_xor);
    or  g_or_co   (co, ab_and, ci_and);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Serial N-bit adder: one full-adder cell stepped LSB first, once per clock.
//  clk   : rising-edge clock
//  rst   : asynchronous active-high reset
//  start : request an add; accepted only while ready=1
//  a, b  : operands, captured with an accepted start
//  cin   : carry in, captured with an accepted start
//  ready : start will be accepted (IDLE or DONE)
//  busy  : add in progress (RUN)
//  done  : one-cycle pulse, sum/cout just updated
//  sum   : result, held until the next completion
//  cout  : carry out, held with sum
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned    CNT_W    = clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [WIDTH-1:0] res_next;
    logic             cell_s;
    logic             cell_co;
    logic             load;
    logic             step;
    logic             finish;

    full_adder_cell u_cell (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    // New sum bit enters at the MSB; after WIDTH steps bit 0 sits at the LSB.
    assign res_next = (res_sh >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));

    // Next-state and control strobes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    finish  = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with registered handshake outputs derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            ready   <= (state_d != ST_RUN);
            busy    <= (state_d == ST_RUN);
            done    <= finish;
        end
    end

    // Operand/result shift registers, carry and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a_sh    <= '0;
            b_sh    <= '0;
            res_sh  <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (load) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (step) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            carry_q <= cell_co;
            res_sh  <= res_next;
            // Counter parks at zero on the last step so it never runs past WIDTH-1.
            cnt_q   <= finish ? '0 : cnt_q + CNT_W'(1);
            if (finish) begin
                sum  <= res_next;
                cout <= cell_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed cases plus random adds on WIDTH=8 and WIDTH=1
// instances, checked against plain a+b+cin arithmetic and a WIDTH+1 edge latency.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start8, cin8, ready8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, cin1, ready1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] res8 = '0;
    logic [1:0] res1 = '0;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present operands with start before edge E0, then scramble inputs once accepted.
    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
        next_cycle();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    endtask

    task automatic issue1(input logic av, input logic bv, input logic cv);
        a1 = av; b1 = bv; cin1 = cv; start1 = 1'b1;
        next_cycle();
        start1 = 1'b0;
        a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
    endtask

    // Edge count includes the accepting edge; bounded so a stuck DUT cannot hang.
    task automatic wait_done8(input int first, output int edges);
        edges = first;
        while (!done8 && edges < 40) begin
            next_cycle();
            edges++;
        end
    endtask

    task automatic wait_done1(input int first, output int edges);
        edges = first;
        while (!done1 && edges < 20) begin
            next_cycle();
            edges++;
        end
    endtask

    task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
        logic [8:0] want;
        int edges;
        want = 9'(av) + 9'(bv) + 9'(cv);
        issue8(av, bv, cv);
        check("busy8_run", busy8, 1'b1);
        check("ready8_run", ready8, 1'b0);
        check("hold8_run", {cout8, sum8}, res8);
        wait_done8(1, edges);
        check("lat8", edges, 9);
        check("sum8", sum8, want[7:0]);
        check("cout8", cout8, want[8]);
        check("ready8_done", ready8, 1'b1);
        check("busy8_done", busy8, 1'b0);
        res8 = want;
    endtask

    task automatic do_op1(input logic av, input logic bv, input logic cv);
        logic [1:0] want;
        int edges;
        want = 2'(av) + 2'(bv) + 2'(cv);
        issue1(av, bv, cv);
        check("busy1_run", busy1, 1'b1);
        check("hold1_run", {cout1, sum1}, res1);
        wait_done1(1, edges);
        check("lat1", edges, 2);
        check("res1", {cout1, sum1}, want);
        check("ready1_done", ready1, 1'b1);
        res1 = want;
    endtask

    // Count done pulses over a quiet window; none are expected.
    task automatic quiet8(input string tag);
        int pulses;
        pulses = 0;
        repeat (12) begin
            next_cycle();
            if (done8) pulses++;
        end
        check(tag, pulses, 0);
    endtask

    initial begin
        int edges;
        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready8", ready8, 1'b1);
        check("rst_busy8", busy8, 1'b0);
        check("rst_done8", done8, 1'b0);
        check("rst_res8", {cout8, sum8}, 9'h0);
        check("rst_ready1", ready1, 1'b1);
        check("rst_res1", {cout1, sum1}, 2'h0);
        rst = 1'b0;
        next_cycle();
        check("idle_ready8", ready8, 1'b1);

        // Directed cases with a single-pulse check after each.
        do_op8(8'h35, 8'h4A, 1'b0);
        next_cycle();
        check("pulse8_a", done8, 1'b0);
        check("held8_a", {cout8, sum8}, res8);
        do_op8(8'hFF, 8'h01, 1'b0);
        next_cycle();
        check("pulse8_b", done8, 1'b0);
        do_op8(8'hFF, 8'h00, 1'b1);
        next_cycle();
        check("pulse8_c", done8, 1'b0);

        // start during RUN is ignored and not queued.
        issue8(8'h35, 8'h4A, 1'b0);
        next_cycle();
        a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
        next_cycle();
        start8 = 1'b0;
        check("busy8_ign", busy8, 1'b1);
        wait_done8(3, edges);
        check("lat8_ign", edges, 9);
        check("res8_ign", {cout8, sum8}, 9'h07F);
        res8 = 9'h07F;
        quiet8("extra_done8");

        // Reset in RUN cycle 4 aborts and clears the result.
        issue8(8'h12, 8'h34, 1'b0);
        repeat (3) next_cycle();
        check("busy8_pre_rst", busy8, 1'b1);
        rst = 1'b1;
        #1;
        check("abort_res8", {cout8, sum8}, 9'h0);
        check("abort_busy8", busy8, 1'b0);
        check("abort_ready8", ready8, 1'b1);
        check("abort_done8", done8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        res8 = '0;
        quiet8("abort_no_done8");
        check("abort_held8", {cout8, sum8}, 9'h0);

        // Back-to-back: start held in DONE launches the next add immediately.
        do_op8(8'h55, 8'h22, 1'b0);
        do_op8(8'h10, 8'h20, 1'b0);
        check("b2b_sum8", sum8, 8'h30);
        next_cycle();

        // Random adds, mixing idle gaps and back-to-back issues.
        for (int i = 0; i < 150; i++) begin
            do_op8(8'($urandom), 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                next_cycle();
                check("gap8", done8, 1'b0);
            end
        end

        // WIDTH=1 instance.
        do_op1(1'b1, 1'b1, 1'b1);
        check("w1_directed", {cout1, sum1}, 2'b11);
        next_cycle();
        check("pulse1", done1, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            do_op1(1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                next_cycle();
                check("gap1", done1, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
